// File: rtl/trap_shaper_param.sv
// trap_shaper_param: trapezoidal pulse shaper with pole-zero cancellation in a 3-stage pipeline
// Ports: clk, reset (sync, active-high, overrides clear), in_valid/in_data (signed sample in),
//        clear (sync state clear, wins over in_valid), out_valid/out_data/out_sat (shaped,
//        saturated sample and clip flag, 3 cycles after acceptance), primed (K+L samples seen)
module trap_shaper_param #(
  parameter int DATA_W = 16,
  parameter int K = 8,
  parameter int L = 12,
  parameter int M = 0,
  parameter int ACC_W = 48,
  parameter int SHIFT = 0,
  parameter int OUT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     clear,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat,
  output logic                     primed
);
  localparam int N = K + L;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int DW = DATA_W + 2;
  localparam logic [AW:0] N_A = (AW+1)'(N);
  localparam logic [AW:0] K_A = (AW+1)'(K);
  localparam logic [AW:0] L_A = (AW+1)'(L);
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [CW-1:0] N_C = CW'(N);
  localparam logic signed [ACC_W-1:0] M_A = ACC_W'(M);
  localparam logic signed [ACC_W-1:0] O_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] O_MIN = ~O_MAX;
  if (K < 1 || K > 256 || L < K || K + L > 512) begin : g_bad_params
    $error("trap_shaper_param: K must be 1..256, L >= K and K+L <= 512");
  end
  logic signed [DATA_W-1:0] hist_q [N];
  logic signed [DATA_W-1:0] x0_q, xk_q, xl_q, xkl_q;
  logic [AW-1:0] wp_q, wp_d, ak, al;
  logic [AW:0] sk, sl;
  logic [CW-1:0] cnt_q, cnt_d;
  logic v1_q, v2_q, out_valid_q, out_sat_q, kill, hi, lo;
  logic signed [DW-1:0] d;
  logic signed [ACC_W-1:0] de, d2_q, p_q, r, s_q, s_d, sh;
  logic signed [OUT_W-1:0] out_data_q;
  assign kill = reset | clear;
  // x[n-K] lives L entries ahead of the write pointer, x[n-L] K entries ahead,
  // and x[n-K-L] is the entry about to be overwritten.
  assign sk = {1'b0, wp_q} + L_A;
  assign sl = {1'b0, wp_q} + K_A;
  assign ak = AW'(sk >= N_A ? sk - N_A : sk);
  assign al = AW'(sl >= N_A ? sl - N_A : sl);
  assign wp_d = wp_q == LAST ? '0 : wp_q + 1'b1;
  assign cnt_d = cnt_q == N_C ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk) begin
    if (kill) begin
      for (int i = 0; i < N; i++) hist_q[i] <= '0;
      wp_q <= '0;
      cnt_q <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        hist_q[wp_q] <= in_data;
        wp_q <= wp_d;
        cnt_q <= cnt_d;
        x0_q <= in_data;
        xk_q <= hist_q[ak];
        xl_q <= hist_q[al];
        xkl_q <= hist_q[wp_q];
      end
    end
  end
  assign d = DW'(x0_q) - DW'(xk_q) - DW'(xl_q) + DW'(xkl_q);
  assign de = ACC_W'(d);
  always_ff @(posedge clk) begin
    if (kill) begin
      v2_q <= 1'b0;
      p_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        p_q <= p_q + de;
        d2_q <= de;
      end
    end
  end
  assign r = p_q + M_A * d2_q;
  assign s_d = s_q + r;
  assign sh = s_d >>> SHIFT;
  assign hi = sh > O_MAX;
  assign lo = sh < O_MIN;
  always_ff @(posedge clk) begin
    if (kill) begin
      out_valid_q <= 1'b0;
      s_q <= '0;
      out_data_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      out_valid_q <= v2_q;
      if (v2_q) begin
        s_q <= s_d;
        out_data_q <= hi ? OUT_W'(O_MAX) : lo ? OUT_W'(O_MIN) : sh[OUT_W-1:0];
        out_sat_q <= hi | lo;
      end
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_sat = out_sat_q;
  assign primed = cnt_q == N_C;
endmodule

// File: doc/trap_shaper_param.md
TRAP_SHAPER_PARAM -- requirements
Module: trap_shaper_param

Interface
REQ-001 Parameter DATA_W, default 16: input sample width, signed two's complement.
REQ-002 Parameter K, default 8: rise/fall length in samples, range 1..256.
REQ-003 Parameter L, default 12: rise plus flat-top length in samples, L >= K, K+L <= 512.
REQ-004 Parameter M, default 0: pole-zero cancellation multiplier, signed integer, range -2^15..2^15-1.
REQ-005 Parameter ACC_W, default 48: width of all internal accumulators.
REQ-006 Parameter SHIFT, default 0: arithmetic right shift applied to s before output.
REQ-007 Parameter OUT_W, default 16: output sample width, signed.
REQ-008 clk  input  1  single clock; all logic on rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 in_valid  input  1  in_data is accepted on this cycle; gaps allowed.
REQ-011 in_data  input  DATA_W  signed input sample x[n].
REQ-012 clear  input  1  synchronous state clear without a full reset.
REQ-013 out_valid  output  1  out_data and out_sat are valid this cycle.
REQ-014 out_data  output  OUT_W  signed shaped sample.
REQ-015 out_sat  output  1  out_data was clipped on this sample.
REQ-016 primed  output  1  K+L samples have been accepted since the last reset or clear.

Function
REQ-017 The block shall advance the filter index n once per accepted sample only, meaning once per cycle with in_valid=1 and clear=0; cycles with in_valid=0 shall not change any filter state.
REQ-018 The block shall compute d[n] = x[n] - x[n-K] - x[n-L] + x[n-K-L], p[n] = p[n-1] + d[n], r[n] = p[n] + M*d[n], s[n] = s[n-1] + r[n].
REQ-019 Samples older than the last reset or clear shall read as 0.
REQ-020 History shall be held in a circular buffer of depth K+L (register or RAM), with one write pointer that wraps from K+L-1 to 0; x[n-K], x[n-L] and x[n-K-L] shall be read at fixed offsets modulo K+L.
REQ-021 When K = L, the x[n-K] and x[n-L] taps are the same address, and d[n] shall equal x[n] - 2*x[n-K] + x[n-2K].
REQ-022 d[n] shall be DATA_W+2 bits wide and sign-extended into ACC_W; p, r and s shall be ACC_W bits and shall wrap modulo 2^ACC_W, with no saturation inside the loop.
REQ-023 out_data shall be s[n] >>> SHIFT, saturated to the range -2^(OUT_W-1)..2^(OUT_W-1)-1; out_sat shall be 1 exactly on the samples that were clipped.
REQ-024 Latency shall be fixed at 3 cycles: a sample accepted at cycle t shall produce out_valid=1 at cycle t+3, and out_valid shall have the same gap pattern as in_valid.
REQ-025 The pipeline shall have three stages: stage 1 reads the buffer and writes x[n]; stage 2 computes d and p; stage 3 computes r, s and the saturated output register.
REQ-026 Sample counter: primed shall go high in the cycle after the (K+L)-th accepted sample, then stay high until the next reset or clear; the counter shall saturate and never wrap.
REQ-027 When clear=1, the block shall zero p, s, the sample counter, the write pointer and every buffer entry (or mark them invalid so they read as 0), within at most K+L cycles.
REQ-028 While a clear is in progress, in_valid shall be ignored, and no out_valid shall be generated for samples accepted before the clear that are still in the pipeline.
REQ-029 If clear and in_valid are asserted in the same cycle, clear shall win and the sample shall be dropped.
REQ-030 Parameters violating REQ-002 or REQ-003 shall cause an elaboration-time error.

Reset
REQ-031 While reset=1, the block shall drive out_valid=0, out_data=0, out_sat=0 and primed=0, and zero p, s, the pointer, the counter and the pipeline valids; reset shall override clear.
REQ-032 Reset asserted mid-stream shall discard all in-flight samples, with no out_valid in the following cycles.
REQ-033 Buffer contents after reset shall read as 0, by the same mechanism as clear; out_valid may be suppressed for up to K+L cycles after reset while the buffer is cleared.

Verification
REQ-034 Impulse test, K=8, L=12, M=0, SHIFT=0: a single sample of 100 followed by zeros shall produce an output ramp 100, 200 .. 800 over 8 samples, a flat top of 800 for 4 samples, a ramp down to 0, and 0 from sample 20 onward.
REQ-035 Gapped input test: the REQ-034 stimulus with in_valid=0 for 2 cycles between every 2 samples shall produce the identical out_data sequence, each out_valid exactly 3 cycles after its in_valid.
REQ-036 Saturation test, OUT_W=16: a DC input of 32767 shall make out_data clip at 32767 with out_sat=1 on those samples only, and internal s shall remain exact, checked against a reference model.
REQ-037 Clear test: clear asserted mid-pulse together with in_valid shall drop that sample and drive primed low; a fresh impulse after clear completes shall give the same response as in REQ-034.
REQ-038 Wrap test, K=L=4: running for at least 3*(K+L) samples of random data shall give outputs that match a golden model bit-exactly, with primed rising after exactly 8 accepted samples.
REQ-039 Pole-zero test: an exponential input 1000*(1-1/64)^n with M=63 shall produce a trapezoid with a flat top within ±1 LSB, with no undershoot.
